// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port and packed-word output handshake used by fifo_rd_packer.
// The packer drives through the master modport; the environment uses slave.
interface fifo_rd_packer_if #(
    parameter int DATAWIDTH = 8,
    parameter int PACK      = 4
);
    localparam int CNTW = $clog2(PACK) + 1;

    logic                      fifo_empty;
    logic [DATAWIDTH-1:0]      fifo_data;
    logic                      fifo_ren;
    logic                      flush;
    logic [DATAWIDTH*PACK-1:0] out_data;
    logic [CNTW-1:0]           out_cnt;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  fifo_empty, fifo_data, flush, out_ready,
        output fifo_ren, out_data, out_cnt, out_valid
    );

    modport slave (
        output fifo_empty, fifo_data, flush, out_ready,
        input  fifo_ren, out_data, out_cnt, out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops PACK FIFO words into one wide word on a registered
// valid/ready output; flush emits a partially filled word with its lane count.
module fifo_rd_packer #(
    parameter int DATAWIDTH = 8,
    parameter int PACK      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_rd_packer_if.master  bus
);
    localparam int          CNTW  = $clog2(PACK) + 1;
    localparam int          CW    = $clog2(PACK);
    localparam int unsigned LANES = PACK - 1;
    localparam int          AW    = DATAWIDTH * (PACK - 1);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    typedef enum logic {ST_RUN, ST_PENDING} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             acc_q;
    logic [DATAWIDTH*PACK-1:0] data_q;
    logic [DATAWIDTH*PACK-1:0] partial;
    logic [CNTW-1:0]           ocnt_q;
    logic                      valid_q;
    logic                      out_free;
    logic                      pop;
    logic                      full_load;
    logic                      flush_load;

    always_comb begin
        out_free   = !valid_q || bus.out_ready;
        pop        = rst_n && !bus.fifo_empty && (state_q == ST_RUN) &&
                     ((cnt_q != LAST) || out_free);
        full_load  = pop && (cnt_q == LAST);
        flush_load = (state_q == ST_PENDING) && out_free;

        cnt_d = cnt_q;
        if (full_load || flush_load) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + 1'b1;
        end

        // flush is judged against the lane count after this cycle's pop
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (bus.flush && (cnt_d != '0)) state_d = ST_PENDING;
            ST_PENDING: if (out_free) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        // stale accumulator lanes at or above cnt must leave as zero
        partial = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i < 32'(cnt_q)) begin
                partial[i*DATAWIDTH +: DATAWIDTH] = acc_q[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                if (pop && (cnt_q == CW'(i))) begin
                    acc_q[i*DATAWIDTH +: DATAWIDTH] <= bus.fifo_data;
                end
            end
            if (full_load) begin
                data_q  <= {bus.fifo_data, acc_q};
                ocnt_q  <= CNTW'(PACK);
                valid_q <= 1'b1;
            end else if (flush_load) begin
                data_q  <= partial;
                ocnt_q  <= {1'b0, cnt_q};
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_ren  = pop;
    assign bus.out_data  = data_q;
    assign bus.out_cnt   = ocnt_q;
    assign bus.out_valid = valid_q;
endmodule
